// File: rtl/alu_result_buffer.sv
// Two-entry in-order skid buffer that carries ALU results from execute to memory stage.
// ReadyE and ValidM come from registered occupancy only, so no combinational paths cross the stage.
module alu_result_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  output logic             ReadyE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic             CarryOutE,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             FlushM,
  output logic             ValidM,
  input  logic             ReadyM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic             CarryOutM,
  output logic [4:0]       RdM,
  output logic             RegWriteM,
  output logic [1:0]       Count,
  output logic [15:0]      StallCount
);

  localparam int EW = WIDTH + 7;

  logic [EW-1:0] head_q;
  logic [EW-1:0] tail_q;
  logic [EW-1:0] entry_in;
  logic [1:0]    count_q;
  logic [15:0]   stall_q;
  logic          push;
  logic          pop;

  assign ReadyE   = (count_q != 2'd2);
  assign ValidM   = (count_q != 2'd0);
  assign entry_in = {ALUResultE, CarryOutE, RdE, RegWriteE};
  assign push     = ValidE && ReadyE && !FlushM;
  assign pop      = ValidM && ReadyM && !FlushM;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      stall_q <= 16'd0;
    end else begin
      // Stall accounting is independent of flush so lost cycles stay visible.
      if (ValidM && !ReadyM && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end

      if (FlushM) begin
        count_q <= 2'd0;
      end else begin
        case (count_q)
          2'd0: begin
            if (push) begin
              head_q  <= entry_in;
              count_q <= 2'd1;
            end
          end
          2'd1: begin
            case ({push, pop})
              2'b10: begin
                tail_q  <= entry_in;
                count_q <= 2'd2;
              end
              2'b01: count_q <= 2'd0;
              2'b11: head_q  <= entry_in;
              default: ;
            endcase
          end
          default: begin
            if (pop) begin
              head_q  <= tail_q;
              count_q <= 2'd1;
            end
          end
        endcase
      end
    end
  end

  assign {ALUResultM, CarryOutM, RdM, RegWriteM} = ValidM ? head_q : '0;
  assign Count      = count_q;
  assign StallCount = stall_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidE;
  logic        ReadyE;
  logic [31:0] ALUResultE;
  logic        CarryOutE;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        FlushM;
  logic        ValidM;
  logic        ReadyM;
  logic [31:0] ALUResultM;
  logic        CarryOutM;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [1:0]  Count;
  logic [15:0] StallCount;

  int checks = 0;
  int failures = 0;

  logic [38:0] mq[$];
  int          m_stall = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .ValidE(ValidE), .ReadyE(ReadyE),
    .ALUResultE(ALUResultE), .CarryOutE(CarryOutE), .RdE(RdE), .RegWriteE(RegWriteE),
    .FlushM(FlushM), .ValidM(ValidM), .ReadyM(ReadyM),
    .ALUResultM(ALUResultM), .CarryOutM(CarryOutM), .RdM(RdM), .RegWriteM(RegWriteM),
    .Count(Count), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what one rising edge does to the queue, given the current inputs.
  task automatic model_step();
    bit can_take;
    bit has_head;
    can_take = (mq.size() < 2);
    has_head = (mq.size() != 0);
    if (reset) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (has_head && !ReadyM && m_stall < 65535) m_stall++;
      if (FlushM) begin
        mq.delete();
      end else begin
        if (has_head && ReadyM) void'(mq.pop_front());
        if (ValidE && can_take) mq.push_back({ALUResultE, CarryOutE, RdE, RegWriteE});
      end
    end
  endtask

  task automatic compare_all();
    logic [38:0] exp_head;
    exp_head = (mq.size() != 0) ? mq[0] : 39'd0;
    chk("ready_e", ReadyE, mq.size() < 2);
    chk("valid_m", ValidM, mq.size() != 0);
    chk("count", Count, mq.size());
    chk("stall_count", StallCount, m_stall);
    chk("head_fields", {ALUResultM, CarryOutM, RdM, RegWriteM}, exp_head);
  endtask

  task automatic drive(input bit rst, input bit ve, input logic [31:0] res, input bit c,
                       input logic [4:0] rd, input bit rw, input bit rm, input bit fl);
    reset = rst; ValidE = ve; ALUResultE = res; CarryOutE = c;
    RdE = rd; RegWriteE = rw; ReadyM = rm; FlushM = fl;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit rm);
    drive(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd31, 1'b1, rm, 1'b0);
  endtask

  int saved_stall;

  initial begin
    reset = 1'b1; ValidE = 1'b0; ALUResultE = '0; CarryOutE = 1'b0;
    RdE = '0; RegWriteE = 1'b0; ReadyM = 1'b0; FlushM = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h77, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
    chk("rst_ready_e", ReadyE, 1);
    chk("rst_valid_m", ValidM, 0);
    chk("rst_count", Count, 0);
    chk("rst_result", ALUResultM, 0);

    // Pass-through with one cycle latency.
    drive(1'b0, 1'b1, 32'h0000_0005, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    chk("pt_valid", ValidM, 1);
    chk("pt_result", ALUResultM, 32'h5);
    chk("pt_rd", RdM, 3);
    idle(1'b1);
    chk("pt_drained_valid", ValidM, 0);
    chk("pt_drained_count", Count, 0);

    // Fill under backpressure; third push must be ignored.
    drive(1'b0, 1'b1, 32'hA, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hB, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("fill_count", Count, 2);
    chk("fill_ready_e", ReadyE, 0);
    drive(1'b0, 1'b1, 32'hC, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("fill_blocked_count", Count, 2);
    chk("fill_head_a", ALUResultM, 32'hA);
    idle(1'b1);
    chk("drain_b", ALUResultM, 32'hB);
    idle(1'b1);
    chk("drain_empty", ValidM, 0);

    // Simultaneous push and pop with one entry held.
    drive(1'b0, 1'b1, 32'h11, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h22, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    chk("pp_count", Count, 1);
    chk("pp_head", ALUResultM, 32'h22);
    idle(1'b1);

    // Flush while full, with a concurrent push.
    drive(1'b0, 1'b1, 32'h40, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h41, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    saved_stall = StallCount;
    drive(1'b0, 1'b1, 32'h33, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    chk("flush_count", Count, 0);
    chk("flush_valid", ValidM, 0);
    chk("flush_stall_kept", StallCount, saved_stall + 1);
    idle(1'b1);
    chk("flush_no_33", ValidM, 0);

    // Reset while full overrides the concurrent push and pop.
    drive(1'b0, 1'b1, 32'h50, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h51, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h52, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0);
    chk("midrst_count", Count, 0);
    chk("midrst_ready_e", ReadyE, 1);
    chk("midrst_valid", ValidM, 0);
    chk("midrst_data", {ALUResultM, CarryOutM, RdM, RegWriteM}, 0);
    chk("midrst_stall", StallCount, 0);

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            5'($urandom_range(0, 31)), $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 29) == 0));
    end

    // Long stall saturates the counter without wrapping.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h99, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65600; i++) idle(1'b0);
    chk("stall_saturated", StallCount, 16'hFFFF);
    chk("stall_head_held", ALUResultM, 32'h99);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("stall_reset", StallCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, result data width (ALUResult width).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port ValidE  input  1  execute stage presents a result this cycle.
REQ-005 The block SHALL have port ReadyE  output  1  buffer can accept a result this cycle.
REQ-006 The block SHALL have port ALUResultE  input  WIDTH  ALU result from execute stage.
REQ-007 The block SHALL have port CarryOutE  input  1  ALU carry flag from execute stage.
REQ-008 The block SHALL have port RdE  input  5  destination register index.
REQ-009 The block SHALL have port RegWriteE  input  1  result is to be written back.
REQ-010 The block SHALL have port FlushM  input  1  discard all buffered and incoming results.
REQ-011 The block SHALL have port ValidM  output  1  head entry valid toward memory stage.
REQ-012 The block SHALL have port ReadyM  input  1  memory stage accepts head entry this cycle.
REQ-013 The block SHALL have ports ALUResultM (WIDTH), CarryOutM (1), RdM (5), RegWriteM (1), all outputs, head-entry fields.
REQ-014 The block SHALL have port Count  output  2  number of occupied entries (0..2).
REQ-015 The block SHALL have port StallCount  output  16  cycles with ValidM=1 and ReadyM=0.

Function
REQ-016 The block SHALL be a 2-entry in-order FIFO (skid buffer) of {ALUResult, CarryOut, Rd, RegWrite}.
REQ-017 Push SHALL occur on a rising edge when ValidE=1, ReadyE=1, FlushM=0.
REQ-018 Pop SHALL occur on a rising edge when ValidM=1, ReadyM=1, FlushM=0.
REQ-019 ReadyE SHALL equal (Count<2), derived from registered state only; no combinational path from ReadyM or ValidE to ReadyE.
REQ-020 ValidM SHALL equal (Count!=0); no combinational path from ValidE to ValidM.
REQ-021 Latency SHALL be 1 cycle: an entry pushed into an empty buffer at edge N is presented with ValidM=1 in the cycle after edge N.
REQ-022 When ValidM=0, ALUResultM, CarryOutM, RdM, RegWriteM SHALL be driven to 0.
REQ-023 Order SHALL be preserved: entries leave in push order; no entry is dropped or duplicated absent flush.
REQ-024 Count=0: only push possible; pop not possible; Count becomes 1 on push.
REQ-025 Count=1, simultaneous push and pop: Count stays 1; new entry becomes head on that edge.
REQ-026 Count=2: ReadyE=0, push blocked regardless of ValidE; pop reduces Count to 1, second entry becomes head.
REQ-027 FlushM=1 SHALL set Count to 0 at that edge and discard any simultaneous push and pop; ValidM=0 next cycle.
REQ-028 Data fields of an entry SHALL be unchanged while it stays in the buffer, independent of input changes.
REQ-029 StallCount SHALL increment by 1 on every edge where ValidM=1 and ReadyM=0, saturating at 0xFFFF; FlushM SHALL NOT clear it.

Reset
REQ-030 reset=1 at an edge SHALL set Count=0, StallCount=0, all storage to 0; reset SHALL override push, pop and flush.
REQ-031 After reset: ReadyE=1, ValidM=0, all M data outputs 0, Count=0.
REQ-032 Reset asserted mid-operation (Count=2) SHALL discard both entries at that edge.

Verification
REQ-033 Pass-through: push {0x0000_0005,C=0,Rd=3,RW=1}, ReadyM=1 -> next cycle ValidM=1, ALUResultM=0x5, RdM=3; following cycle ValidM=0, Count=0.
REQ-034 Fill/backpressure: ReadyM=0, push 0xA then 0xB -> Count=2, ReadyE=0, third push 0xC ignored; raise ReadyM -> outputs 0xA then 0xB, 0xC never appears.
REQ-035 Simultaneous push/pop at Count=1 (head 0x11, push 0x22, ReadyM=1) -> Count stays 1, ALUResultM=0x22 next cycle.
REQ-036 Flush: Count=2 with FlushM=1 and ValidE=1 (0x33) same edge -> Count=0, ValidM=0, 0x33 discarded, StallCount retained.
REQ-037 Stall counter: ValidM=1, ReadyM=0 for 70000 cycles -> StallCount=0xFFFF, no wrap; reset -> StallCount=0.
REQ-038 Reset mid-operation: Count=2, reset=1 with ValidE=1 and ReadyM=1 -> Count=0, ReadyE=1, ValidM=0, all M data outputs 0.
